if_id_fetch: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the MIPS datapath.
- Holds the PC and fetches from instruction memory over a req/ack handshake.
- Latches the instruction and PC+4 into IF/ID and splits out decode fields; id_imm16 drives the 16-bit input of the sign-extension stage directly.
- Handles pipeline stall, redirect (branch/jump) and flush.

---
 rtl/if_id_fetch.sv | 144 ++++++++++++++
 tb/tb_if_id_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch.sv
// MIPS instruction-fetch stage with IF/ID register, req/ack memory handshake and one-entry skid buffer.
// Optional macro FETCH_PERF_COUNT_EN adds perf_fetched / perf_bubbles counters.
module if_id_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm16
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic        started;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;
  logic        accept;

  assign pc_inc    = pc + PC_STEP;
  assign imem_addr = pc;
  // An ack counts only against a live request and is dropped under redirect.
  assign accept    = imem_req && imem_ack && !redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = FETCH;
    end else begin
      case (state)
        FETCH:   if (accept && stall) state_next = HOLD;
        HOLD:    if (!stall)          state_next = FETCH;
        default: state_next = FETCH;
      endcase
    end
  end

  // started keeps imem_req low until the first edge after reset release.
  always_comb begin
    imem_req = started && (state == FETCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= PC_RESET;
      started    <= 1'b0;
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc4     <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else begin
      started <= 1'b1;
      if (redirect) begin
        pc         <= redirect_pc;
        id_valid   <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        case (state)
          FETCH: begin
            if (accept) begin
              pc <= pc_inc;
              if (!stall) begin
                id_instr <= imem_rdata;
                id_pc4   <= pc_inc;
                id_valid <= 1'b1;
              end else begin
                skid_instr <= imem_rdata;
                skid_pc4   <= pc_inc;
                skid_valid <= 1'b1;
              end
            end else if (!stall) begin
              id_valid <= 1'b0;
            end
          end
          HOLD: begin
            if (!stall) begin
              id_instr   <= skid_instr;
              id_pc4     <= skid_pc4;
              id_valid   <= skid_valid;
              skid_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic bubble;
  assign bubble = started && !stall &&
                  (redirect || (state == FETCH && !(imem_req && imem_ack)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (accept) perf_fetched <= perf_fetched + 32'd1;
      if (bubble) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

  assign id_opcode = id_instr[31:26];
  assign id_rs     = id_instr[25:21];
  assign id_rt     = id_instr[20:16];
  assign id_rd     = id_instr[15:11];
  assign id_shamt  = id_instr[10:6];
  assign id_funct  = id_instr[5:0];
  assign id_imm16  = id_instr[15:0];

endmodule

// File: tb/tb_if_id_fetch.sv
// Directed self-checking bench for if_id_fetch (PC_RESET = 0x0040_0000).
module tb_if_id_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [5:0]  id_funct;
  logic [15:0] id_imm16;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  int checks = 0;
  int errors = 0;

  if_id_fetch #(.PC_RESET(32'h0040_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc4(id_pc4), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_funct(id_funct), .id_imm16(id_imm16)
`ifdef FETCH_PERF_COUNT_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rdata = '0; imem_ack = 1'b0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", id_instr); end
    checks++; if (id_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h want 0", id_pc4); end
    checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL rst_addr got %h want 00400000", imem_addr); end
    rst = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL start_req got %b want 1", imem_req); end
  endtask

  task automatic test_fetch();
    checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL f0_addr got %h want 00400000", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL f1_valid got %b want 1", id_valid); end
    checks++; if (id_imm16 !== 16'h0005) begin errors++; $display("FAIL f1_imm got %h want 0005", id_imm16); end
    checks++; if (id_pc4 !== 32'h0040_0004) begin errors++; $display("FAIL f1_pc4 got %h want 00400004", id_pc4); end
    checks++; if (imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL f1_addr got %h want 00400004", imem_addr); end
    imem_rdata = 32'h8C09_FFFC;
    tick();
    checks++; if (id_imm16 !== 16'hFFFC) begin errors++; $display("FAIL f2_imm got %h want fffc", id_imm16); end
    checks++; if (id_pc4 !== 32'h0040_0008) begin errors++; $display("FAIL f2_pc4 got %h want 00400008", id_pc4); end
    checks++; if (id_opcode !== 6'h23) begin errors++; $display("FAIL f2_opcode got %h want 23", id_opcode); end
    checks++; if (id_rt !== 5'd9) begin errors++; $display("FAIL f2_rt got %0d want 9", id_rt); end
    checks++; if (id_rs !== 5'd0) begin errors++; $display("FAIL f2_rs got %0d want 0", id_rs); end
    checks++; if (imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL f2_addr got %h want 00400008", imem_addr); end
  endtask

  task automatic test_stall_skid();
    imem_ack = 1'b1; imem_rdata = 32'h0109_5020; stall = 1'b1;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d] got %b want 0", i, imem_req); end
      checks++; if (id_instr !== 32'h8C09_FFFC) begin errors++; $display("FAIL hold_instr[%0d] got %h want 8c09fffc", i, id_instr); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b want 1", i, id_valid); end
      if (i < 2) tick();
    end
    stall = 1'b0;
    tick();
    checks++; if (id_instr !== 32'h0109_5020) begin errors++; $display("FAIL skid_instr got %h want 01095020", id_instr); end
    checks++; if (id_pc4 !== 32'h0040_000C) begin errors++; $display("FAIL skid_pc4 got %h want 0040000c", id_pc4); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL skid_valid got %b want 1", id_valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL skid_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0040_000C) begin errors++; $display("FAIL skid_addr got %h want 0040000c", imem_addr); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL skid_nodup got %b want 0", id_valid); end
  endtask

  task automatic test_redirect();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    redirect = 1'b1; redirect_pc = 32'h0040_0100;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", id_valid); end
    checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL redir_addr got %h want 00400100", imem_addr); end
    checks++; if (id_instr !== 32'h0109_5020) begin errors++; $display("FAIL redir_drop got %h want 01095020", id_instr); end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL lat_valid[%0d] got %b want 0", i, id_valid); end
      checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL lat_addr[%0d] got %h want 00400100", i, imem_addr); end
    end
    imem_ack = 1'b1; imem_rdata = 32'h3C01_1234;
    tick();
    imem_ack = 1'b0;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL lat_done got %b want 1", id_valid); end
    checks++; if (id_opcode !== 6'h0F) begin errors++; $display("FAIL lat_opcode got %h want 0f", id_opcode); end
    checks++; if (id_rd !== 5'd2) begin errors++; $display("FAIL lat_rd got %0d want 2", id_rd); end
    checks++; if (id_shamt !== 5'd8) begin errors++; $display("FAIL lat_shamt got %0d want 8", id_shamt); end
    checks++; if (id_funct !== 6'h34) begin errors++; $display("FAIL lat_funct got %h want 34", id_funct); end
    checks++; if (imem_addr !== 32'h0040_0104) begin errors++; $display("FAIL lat_addr_next got %h want 00400104", imem_addr); end
  endtask

  task automatic test_async_reset();
    #3 rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL arst_req got %b want 0", imem_req); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL arst_instr got %h want 0", id_instr); end
    checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL arst_addr got %h want 00400000", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    rst = 1'b0;
    tick();
    imem_ack = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL arst_lateack got %b want 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL arst_lateinstr got %h want 0", id_instr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL arst_req_back got %b want 1", imem_req); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
    tick();
    imem_ack = 1'b0;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
    checks++; if (id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want 0", id_pc4); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", id_valid); end
  endtask

`ifdef FETCH_PERF_COUNT_EN
  task automatic test_perf();
    logic [6:0] pattern;
    pattern = 7'b1101011;
    rst = 1'b1;
    tick();
    checks++; if (perf_fetched !== 32'd0) begin errors++; $display("FAIL perf_rst got %0d want 0", perf_fetched); end
    rst = 1'b0;
    tick();
    for (int i = 6; i >= 0; i--) begin
      imem_ack = pattern[i]; imem_rdata = 32'h1000_0000 + 32'(i);
      tick();
    end
    imem_ack = 1'b0; stall = 1'b1;
    tick();
    checks++; if (perf_fetched !== 32'd5) begin errors++; $display("FAIL perf_fetched got %0d want 5", perf_fetched); end
    checks++; if (perf_bubbles !== 32'd2) begin errors++; $display("FAIL perf_bubbles got %0d want 2", perf_bubbles); end
    stall = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_stall_skid();
    test_redirect();
    test_latency();
    test_async_reset();
    test_wrap();
`ifdef FETCH_PERF_COUNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
